param_updown_counter: RTL

//   Parametrised successor to the 4-bit free-running counter. Adds width and

---
 rtl/counter_pkg.sv | 25 ++
 rtl/counter_step.sv | 51 +++++
 rtl/param_updown_counter.sv | 84 ++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the parametrised up/down counter family.
// Contents:
//   DIR_UP / DIR_DN   encodings of the up_dn input
//   clamp_load        limits a parallel-load value to the legal count range
//   is_max            true when a count sits on the top of its range
// Both helpers work on 64-bit operands so that a MODULUS of 2**32 can be
// expressed without overflowing the arithmetic.
package counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Out-of-range load values are pulled down to the highest legal count
    // rather than being truncated, so q can never leave 0..modulus-1.
    function automatic logic [63:0] clamp_load(input logic [63:0] val,
                                               input logic [63:0] modulus);
        return (val < modulus) ? val : (modulus - 64'd1);
    endfunction

    function automatic logic is_max(input logic [63:0] q,
                                    input logic [63:0] modulus);
        return q == (modulus - 64'd1);
    endfunction

endpackage

// File: rtl/counter_step.sv
// Combinational next-state logic for one counter step.
// Ports:
//   i_q         current count
//   i_up_dn     direction (DIR_UP / DIR_DN)
//   o_next_q    count after a step in the requested direction
//   o_at_limit  the step would cross a range limit (top going up, 0 going down)
// The wrap/saturate choice is fixed at elaboration by SATURATE.
module counter_step
    import counter_pkg::*;
#(
    parameter int     WIDTH    = 4,
    parameter longint MODULUS  = 16,
    parameter bit     SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_up_dn,
    output logic [WIDTH-1:0] o_next_q,
    output logic             o_at_limit
);

    // Top of range truncated to WIDTH bits; for MODULUS == 2**WIDTH this is
    // all ones, and the explicit wrap to zero below replaces natural overflow.
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 64'd1);

    logic w_at_max;
    logic w_at_zero;

    assign w_at_max  = is_max(64'(i_q), 64'(MODULUS));
    assign w_at_zero = (i_q == '0);

    always_comb begin
        o_next_q   = i_q;
        o_at_limit = 1'b0;
        if (i_up_dn == DIR_UP) begin
            o_at_limit = w_at_max;
            if (!w_at_max) begin
                o_next_q = i_q + WIDTH'(1);
            end else if (!SATURATE) begin
                o_next_q = '0;
            end
        end else begin
            o_at_limit = w_at_zero;
            if (!w_at_zero) begin
                o_next_q = i_q - WIDTH'(1);
            end else if (!SATURATE) begin
                o_next_q = MAX_Q;
            end
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with count enable, synchronous parallel load,
// elaboration-time wrap/saturate selection, a combinational terminal count for
// cascading and registered overflow/underflow event pulses.
// Ports:
//   clk       rising-edge clock for all state
//   reset     synchronous, active-low clear of q, ovf and unf
//   en        count enable, one step per edge
//   up_dn     1 = up, 0 = down
//   load      synchronous load request (beats en)
//   load_val  value to load, clamped to MODULUS-1
//   q         registered count
//   tc        en & count sitting on the limit in the current direction
//   ovf       one-cycle pulse after an up step attempted at the top
//   unf       one-cycle pulse after a down step attempted at zero
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int     WIDTH    = 4,
    parameter longint MODULUS  = 16,
    parameter bit     SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf,
    output logic             unf
);

    logic [WIDTH-1:0] r_q;
    logic             r_ovf;
    logic             r_unf;

    logic [WIDTH-1:0] w_next_q;
    logic             w_at_limit;
    logic [WIDTH-1:0] w_load_q;

    counter_step #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_step (
        .i_q        (r_q),
        .i_up_dn    (up_dn),
        .o_next_q   (w_next_q),
        .o_at_limit (w_at_limit)
    );

    assign w_load_q = WIDTH'(clamp_load(64'(load_val), 64'(MODULUS)));

    // Priority reset > load > en > hold. The pulses are only ever set by an
    // enabled step at a limit, and the direction decides which one, so ovf
    // and unf can never be high together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q   <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (load) begin
            r_q   <= w_load_q;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (en) begin
            r_q   <= w_next_q;
            r_ovf <= w_at_limit && (up_dn == DIR_UP);
            r_unf <= w_at_limit && (up_dn == DIR_DN);
        end else begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end
    end

    // Terminal count stays combinational so a following stage can use it as
    // its enable on the same edge.
    assign tc  = en & w_at_limit;
    assign q   = r_q;
    assign ovf = r_ovf;
    assign unf = r_unf;

endmodule
